// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner: synchronises and debounces the DE0 slide switches and
// turns a rising toggle of SW[8] into a one-shot data word with valid/ready and overrun.
module switch_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        SW,
    output logic [9:0]        sw_stable,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              mode
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, FULL} state_t;

    state_t        state;
    logic [9:0]    s1, s2, cand;
    logic [CW-1:0] cnt;
    logic          prev8, load_evt;

    assign load_evt = sw_stable[8] && !prev8;
    assign mode = sw_stable[9];

    // One counter for the whole vector: a bounce on any bit restarts every bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            cand <= '0;
            cnt <= '0;
            sw_stable <= '0;
            prev8 <= 1'b0;
        end else begin
            s1 <= SW;
            s2 <= s1;
            prev8 <= sw_stable[8];
            if (s2 != cand) begin
                cand <= s2;
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                sw_stable <= cand;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            data_out <= '0;
            data_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (load_evt) begin
                    data_out <= sw_stable[DATA_W-1:0];
                    data_valid <= 1'b1;
                    state <= FULL;
                end
            end else if (load_evt && data_ready) begin
                data_out <= sw_stable[DATA_W-1:0];
            end else if (data_ready) begin
                data_valid <= 1'b0;
                state <= IDLE;
            end
            if (state == FULL && load_evt && !data_ready) overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end
endmodule
